// File: rtl/sem_sequencer_if.sv
// Select/address/read request bus between a requester and a responder.
// Used twice by sem_sequencer: once facing the CPU address/read queue
// (sequencer is the responder) and once facing the semaphore unit
// (sequencer is the requester).
interface sem_sequencer_if;
   logic        sel;    // responder is addressed
   logic [8:3]  aq;     // semaphore number
   logic        read;   // 1 = P (wait), 0 = V (signal)
   logic [31:0] rq;     // result for the read queue
   logic        wrq;    // read-queue write strobe
   logic        done;   // operation finished

   modport master (output sel, aq, read, input  rq, wrq, done);
   modport slave  (input  sel, aq, read, output rq, wrq, done);
endinterface

// File: rtl/sem_sequencer.sv
// sem_sequencer: turns a CPU P (wait) into a blocking acquire by retrying the
// semaphore unit with randomized exponential backoff. V passes straight through.
// Optional feature macro: SEMSEQ_TIMEOUT_EN -- give up after MAXRETRY retries
// and hand the CPU a zero result instead of retrying forever.
module sem_sequencer #(
   parameter int unsigned MAXBACKOFF_LOG2 = 8,    // 1..15
   parameter int unsigned MAXRETRY        = 255   // used only with SEMSEQ_TIMEOUT_EN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [3:0]      whichCore,
   sem_sequencer_if.slave  cpu,
   sem_sequencer_if.master sem,
   output logic            seqBusy
);
   localparam int unsigned WW = MAXBACKOFF_LOG2 + 1;
   localparam logic [WW-1:0] WIN_ONE = {{MAXBACKOFF_LOG2{1'b0}}, 1'b1};
   localparam logic [WW-1:0] WIN_MAX = {1'b1, {MAXBACKOFF_LOG2{1'b0}}};
   localparam logic [7:0]    MAXRETRY_C = 8'(MAXRETRY);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BACKOFF, S_FINISH} state_t;

   state_t         state_q, state_d;
   logic [8:3]     sem_num_q, sem_num_d;
   logic           op_q, op_d;
   logic [31:0]    result_q, result_d;
   logic [WW-1:0]  window_q, window_d;
   logic [WW-1:0]  bcnt_q, bcnt_d;
   logic [7:0]     retries_q, retries_d;
   logic [15:0]    lfsr_q, lfsr_d;
   logic           retry_exhausted;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Random wait in 1..window (window is always a power of two)
   function automatic logic [WW-1:0] backoff_len(input logic [15:0] rnd, input logic [WW-1:0] win);
      return (rnd[WW-1:0] & (win - WIN_ONE)) + WIN_ONE;
   endfunction

   // Double the window, clamped at 2^MAXBACKOFF_LOG2
   function automatic logic [WW-1:0] window_grow(input logic [WW-1:0] win);
      return win[WW-1] ? WIN_MAX : (win << 1);
   endfunction

   // Retry counter saturates instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

`ifdef SEMSEQ_TIMEOUT_EN
   assign retry_exhausted = (retries_q == MAXRETRY_C);
`else
   logic retry_unused;
   assign retry_exhausted = 1'b0;
   assign retry_unused    = ^{retries_q, MAXRETRY_C};
`endif

   // Next-state: request acceptance, retry decision and backoff countdown
   always_comb begin
      state_d   = state_q;
      sem_num_d = sem_num_q;
      op_d      = op_q;
      result_d  = result_q;
      window_d  = window_q;
      bcnt_d    = bcnt_q;
      retries_d = retries_q;
      lfsr_d    = lfsr_step(lfsr_q);
      case (state_q)
         S_IDLE: begin
            if (cpu.sel) begin
               sem_num_d = cpu.aq;
               op_d      = cpu.read;
               result_d  = '0;
               window_d  = WIN_ONE;
               retries_d = '0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (sem.done) begin
               if (!op_q) begin
                  state_d = S_FINISH;
               end else if (sem.wrq && (sem.rq != '0)) begin
                  result_d = sem.rq;
                  state_d  = S_FINISH;
               end else if (retry_exhausted) begin
                  result_d = '0;
                  state_d  = S_FINISH;
               end else begin
                  bcnt_d    = backoff_len(lfsr_q, window_q);
                  window_d  = window_grow(window_q);
                  retries_d = sat_inc8(retries_q);
                  state_d   = S_BACKOFF;
               end
            end
         end
         S_BACKOFF: begin
            if (bcnt_q == WIN_ONE) state_d = S_ISSUE;
            else                   bcnt_d  = bcnt_q - WIN_ONE;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Control state with synchronous reset; LFSR reseeds from the core number
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         window_q  <= WIN_ONE;
         bcnt_q    <= WIN_ONE;
         retries_q <= '0;
         lfsr_q    <= {12'hACE, whichCore};
      end else begin
         state_q   <= state_d;
         window_q  <= window_d;
         bcnt_q    <= bcnt_d;
         retries_q <= retries_d;
         lfsr_q    <= lfsr_d;
      end
   end

   // Latched request and result; only observed through state-gated outputs
   always_ff @(posedge clock) begin
      sem_num_q <= sem_num_d;
      op_q      <= op_d;
      result_q  <= result_d;
   end

   // Outputs decoded from state so everything is zero outside issue/finish
   always_comb begin
      sem.sel  = 1'b0;
      sem.aq   = '0;
      sem.read = 1'b0;
      cpu.done = 1'b0;
      cpu.wrq  = 1'b0;
      cpu.rq   = '0;
      case (state_q)
         S_ISSUE: begin
            sem.sel  = 1'b1;
            sem.aq   = sem_num_q;
            sem.read = op_q;
         end
         S_FINISH: begin
            cpu.done = 1'b1;
            cpu.wrq  = op_q;
            if (op_q) cpu.rq = result_q;
         end
         default: ;
      endcase
   end

   assign seqBusy = (state_q != S_IDLE);
endmodule

// File: tb/tb_sem_sequencer.sv
// Bench for sem_sequencer: a semaphore-unit responder with randomized latency
// and failure counts, checked against a transaction-level model of the
// retry/backoff rules.
module tb_sem_sequencer;
   localparam int MB = 3;
   localparam int MR = 3;
`ifdef SEMSEQ_TIMEOUT_EN
   localparam bit TIMEOUT = 1'b1;
`else
   localparam bit TIMEOUT = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] core = 4'd0;
   logic       seq_busy;
   logic [15:0] lfsr_m;
   int n_cmp = 0;
   int n_mis = 0;

   sem_sequencer_if cpu_if();
   sem_sequencer_if sem_if();

   sem_sequencer #(.MAXBACKOFF_LOG2(MB), .MAXRETRY(MR)) dut (
      .clock    (clock),
      .reset    (reset),
      .whichCore(core),
      .cpu      (cpu_if),
      .sem      (sem_if),
      .seqBusy  (seq_busy)
   );

   always #5 clock = ~clock;

   // Reference random source: the LFSR sequence the block must draw backoffs from
   always @(posedge clock) begin
      if (reset) lfsr_m <= {12'hACE, core};
      else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_rqSeq"},   cpu_if.rq,   0);
      check_eq({tag, "_wrqSeq"},  cpu_if.wrq,  0);
      check_eq({tag, "_doneSeq"}, cpu_if.done, 0);
      check_eq({tag, "_semSel"},  sem_if.sel,  0);
      check_eq({tag, "_semAq"},   sem_if.aq,   0);
      check_eq({tag, "_semRead"}, sem_if.read, 0);
      check_eq({tag, "_seqBusy"}, seq_busy,    0);
   endtask

   task automatic clear_sem_resp();
      sem_if.done = 1'b0;
      sem_if.wrq  = 1'b0;
      sem_if.rq   = '0;
   endtask

   // Idle cycles with stray semDone pulses that must be ignored
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         sem_if.done = 1'($urandom);
         sem_if.wrq  = 1'b1;
         sem_if.rq   = 32'd1;
         @(negedge clock);
         check_eq("idle_busy", seq_busy, 0);
      end
      clear_sem_resp();
   endtask

   // One CPU request, called and returning on a negedge. The responder fails
   // the first 'fails' P attempts, then answers ok_rq.
   task automatic run_txn(input logic [5:0] sem_n, input bit is_p, input int fails,
                          input logic [31:0] ok_rq, input int dmin, input int dmax,
                          input int budget, input bit expect_hang);
      int attempts = 0;
      int wait_left = 0;
      int gap = 0;
      int exp_gap = 0;
      int win = 1;
      int exp_att;
      bit in_attempt = 1'b0;
      bit in_gap = 1'b0;
      bit want_finish = 1'b0;
      bit finished = 1'b0;
      logic [31:0] exp_rq = '0;
      if (!is_p)                      exp_att = 1;
      else if (TIMEOUT && fails > MR) exp_att = MR + 1;
      else                            exp_att = fails + 1;
      clear_sem_resp();
      cpu_if.aq   = sem_n;
      cpu_if.read = is_p;
      cpu_if.sel  = 1'b1;
      @(negedge clock);
      check_eq("sel_to_semsel", sem_if.sel, 1);
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         clear_sem_resp();
         if (cyc > 0) begin
            cpu_if.aq   = 6'($urandom);
            cpu_if.read = 1'($urandom);
         end
         if (want_finish) begin
            check_eq("done", cpu_if.done, 1);
            check_eq("wrq", cpu_if.wrq, 32'(is_p));
            check_eq("rq", cpu_if.rq, exp_rq);
            check_eq("semsel_fin", sem_if.sel, 0);
            check_eq("attempts", attempts, exp_att);
            cpu_if.sel = 1'b0;
            finished = 1'b1;
         end else begin
            check_eq("no_early_done", cpu_if.done, 0);
            if (sem_if.sel) begin
               if (in_gap) begin
                  check_eq("backoff_len", gap, exp_gap);
                  in_gap = 1'b0;
               end
               if (!in_attempt) begin
                  in_attempt = 1'b1;
                  attempts++;
                  wait_left = int'($urandom_range(dmax, dmin));
               end
               check_eq("sem_aq", sem_if.aq, sem_n);
               check_eq("sem_read", sem_if.read, 32'(is_p));
               if (wait_left == 0) begin
                  in_attempt  = 1'b0;
                  sem_if.done = 1'b1;
                  if (!is_p) begin
                     want_finish = 1'b1;
                     exp_rq = '0;
                  end else if (attempts > fails) begin
                     sem_if.wrq  = 1'b1;
                     sem_if.rq   = ok_rq;
                     want_finish = 1'b1;
                     exp_rq = ok_rq;
                  end else begin
                     sem_if.wrq = 1'b1;
                     sem_if.rq  = '0;
                     if (TIMEOUT && attempts == MR + 1) begin
                        want_finish = 1'b1;
                        exp_rq = '0;
                     end else begin
                        exp_gap = (int'(lfsr_m) & (win - 1)) + 1;
                        win = (win * 2 > (1 << MB)) ? (1 << MB) : win * 2;
                        in_gap = 1'b1;
                        gap = 0;
                     end
                  end
               end else begin
                  wait_left--;
               end
            end else if (in_gap) begin
               gap++;
               if ($urandom_range(1, 0) == 1) begin
                  sem_if.done = 1'b1;
                  sem_if.wrq  = 1'b1;
                  sem_if.rq   = 32'd1;
               end
            end else begin
               check_eq("semsel_held", sem_if.sel, 1);
            end
         end
         @(negedge clock);
      end
      clear_sem_resp();
      if (expect_hang) check_eq("no_done_forever", finished, 0);
      else             check_eq("txn_budget", finished, 1);
      if (finished) begin
         check_eq("done_pulse", cpu_if.done, 0);
         check_eq("idle_after", seq_busy, 0);
      end
   endtask

   // Start a P, optionally fail it once to reach backoff, then reset mid-flight
   task automatic reset_check(input bit in_backoff);
      cpu_if.aq   = 6'd17;
      cpu_if.read = 1'b1;
      cpu_if.sel  = 1'b1;
      @(negedge clock);
      check_eq("rst_pre_issue", sem_if.sel, 1);
      if (in_backoff) begin
         sem_if.done = 1'b1;
         sem_if.wrq  = 1'b1;
         sem_if.rq   = '0;
         @(negedge clock);
         clear_sem_resp();
         check_eq("rst_pre_backoff", seq_busy & ~sem_if.sel, 1);
      end
      cpu_if.sel = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_outputs_zero(in_backoff ? "rst_backoff" : "rst_issue");
   endtask

   initial begin
      core = 4'($urandom);
      cpu_if.sel = 1'b0;
      cpu_if.aq = '0;
      cpu_if.read = 1'b0;
      clear_sem_resp();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clock);

      run_txn(6'd5,  1'b1, 0, 32'd2, 0, 0, 100, 1'b0);
      idle_cycles(3);
      run_txn(6'd63, 1'b1, 2, 32'd1, 0, 2, 200, 1'b0);
      idle_cycles(2);
      run_txn(6'd0,  1'b0, 0, 32'd0, 10, 10, 100, 1'b0);
      idle_cycles(2);
      run_txn(6'($urandom), 1'b1, 20, 32'd1, 0, 1, 2000, 1'b0);
      for (int i = 0; i < 12; i++) begin
         run_txn(6'($urandom), 1'($urandom), int'($urandom_range(6, 0)),
                 32'($urandom_range(2, 1)), 0, 3, 1000, 1'b0);
         idle_cycles(int'($urandom_range(3, 0)));
      end

      run_txn(6'd9, 1'b1, 1000000, 32'd1, 0, 2, 1000, !TIMEOUT);
      cpu_if.sel = 1'b0;
      clear_sem_resp();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_outputs_zero("rst_hang");
      @(negedge clock);

      reset_check(1'b0);
      reset_check(1'b1);
      run_txn(6'd5, 1'b1, 0, 32'd2, 0, 0, 100, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
